// File: rtl/image_ycbcr422_to_444_param.sv
// image_ycbcr422_to_444_param: 4:2:2 {C,Y} to 4:4:4 {Y,Cb,Cr} chroma upsampler, fixed 2-clock latency.
// Define YCBCR444_RANGE_CLAMP_EN to clamp outputs to the video range scaled by 2^(DW-8).
module image_ycbcr422_to_444_param #(
    parameter int DW           = 8,
    parameter bit CB_FIRST_DEF = 1'b1,
    parameter int LAT          = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_cb_first,
    input  logic            per_frame_vsync,
    input  logic            per_frame_href,
    input  logic            per_frame_clken,
    input  logic [2*DW-1:0] per_frame_YCbCr,
    output logic            post_frame_vsync,
    output logic            post_frame_href,
    output logic            post_frame_clken,
    output logic [DW-1:0]   post_img_Y,
    output logic [DW-1:0]   post_img_Cb,
    output logic [DW-1:0]   post_img_Cr,
    output logic            odd_line_err
);
    logic [LAT-1:0] vs_q, vs_d, hs_q, hs_d;
    logic parity_q, parity_d, order_q, order_d, pend_q, pend_d, stb_q, stb_d, err_q, err_d;
    logic [DW-1:0] c0_q, c0_d, y0_q, y0_d, lcb_q, lcb_d, lcr_q, lcr_d, py_q, py_d;
    logic [DW-1:0] y_q, y_d, cb_q, cb_d, cr_q, cr_d;
    logic [DW-1:0] c_in, y_in, cb_n, cr_n, y_r, cb_r, cr_r;
    logic beat, odd, even, flush, vs_rise;

    assign c_in = per_frame_YCbCr[2*DW-1:DW];
    assign y_in = per_frame_YCbCr[DW-1:0];

`ifdef YCBCR444_RANGE_CLAMP_EN
    localparam logic [DW-1:0] LO   = DW'(16 << (DW - 8));
    localparam logic [DW-1:0] HI_Y = DW'(235 << (DW - 8));
    localparam logic [DW-1:0] HI_C = DW'(240 << (DW - 8));

    function automatic logic [DW-1:0] clamp(input logic [DW-1:0] v, input logic [DW-1:0] hi);
        return (v < LO) ? LO : (v > hi) ? hi : v;
    endfunction
`endif

    always_comb begin
        beat     = per_frame_href & per_frame_clken;
        odd      = beat & parity_q;
        even     = beat & ~parity_q;
        flush    = ~per_frame_href & parity_q;
        vs_rise  = per_frame_vsync & ~vs_q[0];
        cb_n     = order_q ? c0_q : c_in;
        cr_n     = order_q ? c_in : c0_q;
        vs_d     = {vs_q[LAT-2:0], per_frame_vsync};
        hs_d     = {hs_q[LAT-2:0], per_frame_href};
        parity_d = per_frame_href & (parity_q ^ beat);
        order_d  = vs_rise ? cfg_cb_first : order_q;
        c0_d     = even ? c_in : c0_q;
        y0_d     = even ? y_in : y0_q;
        // last pair's chroma doubles as the fallback for a flushed dangling beat
        lcb_d    = odd ? cb_n : (per_frame_href ? lcb_q : '0);
        lcr_d    = odd ? cr_n : (per_frame_href ? lcr_q : '0);
        pend_d   = odd;
        py_d     = odd ? y_in : py_q;
        stb_d    = odd | pend_q | flush;
        y_r      = (odd | flush) ? y0_q : pend_q ? py_q : y_q;
        cb_r     = odd ? cb_n : pend_q ? lcb_q : flush ? (order_q ? c0_q : lcb_q) : cb_q;
        cr_r     = odd ? cr_n : pend_q ? lcr_q : flush ? (order_q ? lcr_q : c0_q) : cr_q;
`ifdef YCBCR444_RANGE_CLAMP_EN
        y_d      = clamp(y_r, HI_Y);
        cb_d     = clamp(cb_r, HI_C);
        cr_d     = clamp(cr_r, HI_C);
`else
        y_d      = y_r;
        cb_d     = cb_r;
        cr_d     = cr_r;
`endif
        // flush sets before the vsync edge clears, so a coincident vsync wins
        err_d    = ~vs_rise & (err_q | flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q     <= '0;
            hs_q     <= '0;
            parity_q <= 1'b0;
            order_q  <= CB_FIRST_DEF;
            pend_q   <= 1'b0;
            stb_q    <= 1'b0;
            err_q    <= 1'b0;
            c0_q     <= '0;
            y0_q     <= '0;
            lcb_q    <= '0;
            lcr_q    <= '0;
            py_q     <= '0;
            y_q      <= '0;
            cb_q     <= '0;
            cr_q     <= '0;
        end else begin
            vs_q     <= vs_d;
            hs_q     <= hs_d;
            parity_q <= parity_d;
            order_q  <= order_d;
            pend_q   <= pend_d;
            stb_q    <= stb_d;
            err_q    <= err_d;
            c0_q     <= c0_d;
            y0_q     <= y0_d;
            lcb_q    <= lcb_d;
            lcr_q    <= lcr_d;
            py_q     <= py_d;
            y_q      <= y_d;
            cb_q     <= cb_d;
            cr_q     <= cr_d;
        end
    end

    assign post_frame_vsync = vs_q[LAT-1];
    assign post_frame_href  = hs_q[LAT-1];
    assign post_frame_clken = stb_q;
    assign post_img_Y       = y_q;
    assign post_img_Cb      = cb_q;
    assign post_img_Cr      = cr_q;
    assign odd_line_err     = err_q;
endmodule

// File: tb/tb_image_ycbcr422_to_444_param.sv
// tb_image_ycbcr422_to_444_param: randomized and directed bench against a line-level 4:2:2 -> 4:4:4 model.
module tb_image_ycbcr422_to_444_param;
`ifdef YCBCR444_RANGE_CLAMP_EN
    localparam int DW = 10;
`else
    localparam int DW = 8;
`endif
    logic clk = 1'b0, rst_n = 1'b0, cfg_cb_first = 1'b1;
    logic per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
    logic [2*DW-1:0] per_frame_YCbCr = '0;
    logic post_frame_vsync, post_frame_href, post_frame_clken, odd_line_err;
    logic [DW-1:0] post_img_Y, post_img_Cb, post_img_Cr;

    image_ycbcr422_to_444_param #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_cb_first(cfg_cb_first),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_frame_clken(per_frame_clken), .per_frame_YCbCr(per_frame_YCbCr),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken), .post_img_Y(post_img_Y),
        .post_img_Cb(post_img_Cb), .post_img_Cr(post_img_Cr), .odd_line_err(odd_line_err)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int y; int cb; int cr; bit href;} obs_t;
    typedef struct {int y; int cb; int cr;} pix_t;
    obs_t obs_q[$];
    pix_t exp_q[$];
    int line_c[16], line_y[16];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit model_order = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (post_frame_clken)
            obs_q.push_back('{cyc, int'(post_img_Y), int'(post_img_Cb), int'(post_img_Cr), post_frame_href});

    function automatic int clampv(input int v, input int hi);
`ifdef YCBCR444_RANGE_CLAMP_EN
        int s = 1 << (DW - 8);
        return (v < 16 * s) ? 16 * s : (v > hi * s) ? hi * s : v;
`else
        return v + 0 * hi;
`endif
    endfunction

    // Reference: whole-line view, pairs share chroma, a dangling beat borrows the previous pair's other chroma.
    task automatic model_line(input int n);
        int pcb = 0, pcr = 0, cb, cr;
        for (int k = 0; k + 1 < n; k += 2) begin
            cb = model_order ? line_c[k] : line_c[k+1];
            cr = model_order ? line_c[k+1] : line_c[k];
            exp_q.push_back('{clampv(line_y[k], 235), clampv(cb, 240), clampv(cr, 240)});
            exp_q.push_back('{clampv(line_y[k+1], 235), clampv(cb, 240), clampv(cr, 240)});
            pcb = cb;
            pcr = cr;
        end
        if (n % 2 == 1) begin
            cb = model_order ? line_c[n-1] : pcb;
            cr = model_order ? pcr : line_c[n-1];
            exp_q.push_back('{clampv(line_y[n-1], 235), clampv(cb, 240), clampv(cr, 240)});
        end
    endtask

    task automatic drive(input bit h, input bit ce, input int c, input int y);
        @(posedge clk); #1;
        per_frame_href = h;
        per_frame_clken = ce;
        per_frame_YCbCr = {DW'(c), DW'(y)};
    endtask

    // mode 0: contiguous, 1: clken every 3rd clock, 2: random gaps plus a clken beat with href low
    task automatic drive_line(input int n, input int mode, output int start);
        start = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (mode == 1 ? 2 : mode == 2 ? int'($urandom_range(0, 2)) : 0)
                drive(1'b1, 1'b0, int'($urandom), int'($urandom));
            drive(1'b1, 1'b1, line_c[i], line_y[i]);
            if (i == 0) start = cyc;
        end
        drive(1'b0, mode == 2, int'($urandom), int'($urandom));
        repeat (4) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic pulse_vsync(input bit cfg);
        @(posedge clk); #1;
        cfg_cb_first = cfg;
        per_frame_vsync = 1'b1;
        model_order = cfg;
        repeat (3) @(posedge clk);
        #1 per_frame_vsync = 1'b0;
        cfg_cb_first = ~cfg;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_plan_line();
        line_c[0] = 80; line_y[0] = 10;
        line_c[1] = 90; line_y[1] = 20;
        line_c[2] = 81; line_y[2] = 30;
        line_c[3] = 91; line_y[3] = 40;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken, odd_line_err, post_img_Y, post_img_Cb, post_img_Cr} !== '0) begin
            n_bad++;
            $display("FAIL reset outputs: got Y=%0d Cb=%0d Cr=%0d clken=%b err=%b, want all 0",
                     post_img_Y, post_img_Cb, post_img_Cr, post_frame_clken, odd_line_err);
        end
        #1 rst_n = 1'b1;
        model_order = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_contiguous();
        int s;
        obs_q.delete(); exp_q.delete();
        set_plan_line();
        model_line(4);
        drive_line(4, 0, s);
        n_cmp++;
        if (obs_q.size() != 4) begin n_bad++; $display("FAIL contig count: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].y !== exp_q[i].y || obs_q[i].cb !== exp_q[i].cb || obs_q[i].cr !== exp_q[i].cr
                || obs_q[i].cyc !== s + i + 2 || obs_q[i].href !== 1'b1) begin
                n_bad++;
                $display("FAIL contig px%0d: got (%0d,%0d,%0d) cyc+%0d href=%b want (%0d,%0d,%0d) cyc+%0d href=1",
                         i, obs_q[i].y, obs_q[i].cb, obs_q[i].cr, obs_q[i].cyc - s, obs_q[i].href,
                         exp_q[i].y, exp_q[i].cb, exp_q[i].cr, i + 2);
            end
        end
    endtask

    task automatic test_order();
        int s;
        @(posedge clk); #1;
        cfg_cb_first = 1'b0;
        per_frame_vsync = 1'b1;
        model_order = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (post_frame_vsync !== 1'b0) begin n_bad++; $display("FAIL vsync early: got %b want 0", post_frame_vsync); end
        @(negedge clk);
        n_cmp++;
        if (post_frame_vsync !== 1'b1) begin n_bad++; $display("FAIL vsync delay: got %b want 1", post_frame_vsync); end
        @(posedge clk); #1 per_frame_vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1 cfg_cb_first = 1'b1;
        obs_q.delete(); exp_q.delete();
        set_plan_line();
        model_line(4);
        drive_line(4, 0, s);
        n_cmp++;
        if (obs_q.size() != 4) begin n_bad++; $display("FAIL order count: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].y !== exp_q[i].y || obs_q[i].cb !== exp_q[i].cb || obs_q[i].cr !== exp_q[i].cr) begin
                n_bad++;
                $display("FAIL order px%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         obs_q[i].y, obs_q[i].cb, obs_q[i].cr, exp_q[i].y, exp_q[i].cb, exp_q[i].cr);
            end
        end
        pulse_vsync(1'b1);
    endtask

    task automatic test_sparse();
        int s;
        obs_q.delete(); exp_q.delete();
        set_plan_line();
        model_line(4);
        drive_line(4, 1, s);
        n_cmp++;
        if (obs_q.size() != 4) begin n_bad++; $display("FAIL sparse count: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].y !== exp_q[i].y || obs_q[i].cb !== exp_q[i].cb || obs_q[i].cr !== exp_q[i].cr
                || (i % 2 == 1 && obs_q[i].cyc !== obs_q[i-1].cyc + 1)) begin
                n_bad++;
                $display("FAIL sparse px%0d: got (%0d,%0d,%0d) at cyc %0d want (%0d,%0d,%0d) one clock after its partner",
                         i, obs_q[i].y, obs_q[i].cb, obs_q[i].cr, obs_q[i].cyc, exp_q[i].y, exp_q[i].cb, exp_q[i].cr);
            end
        end
    endtask

    task automatic test_odd_line();
        int s;
        obs_q.delete(); exp_q.delete();
        set_plan_line();
        model_line(3);
        n_cmp++;
        if (odd_line_err !== 1'b0) begin n_bad++; $display("FAIL odd err pre: got %b want 0", odd_line_err); end
        drive_line(3, 0, s);
        n_cmp++;
        if (obs_q.size() != 3) begin n_bad++; $display("FAIL odd count: got %0d want 3", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].y !== exp_q[i].y || obs_q[i].cb !== exp_q[i].cb || obs_q[i].cr !== exp_q[i].cr) begin
                n_bad++;
                $display("FAIL odd px%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         obs_q[i].y, obs_q[i].cb, obs_q[i].cr, exp_q[i].y, exp_q[i].cb, exp_q[i].cr);
            end
        end
        n_cmp++;
        if (odd_line_err !== 1'b1) begin n_bad++; $display("FAIL odd err set: got %b want 1", odd_line_err); end
        pulse_vsync(1'b1);
        n_cmp++;
        if (odd_line_err !== 1'b0) begin n_bad++; $display("FAIL odd err clear: got %b want 0", odd_line_err); end
    endtask

    task automatic test_reset_midline();
        int s;
        obs_q.delete(); exp_q.delete();
        drive(1'b1, 1'b1, 55, 66);
        @(posedge clk); #1;
        rst_n = 1'b0;
        per_frame_href = 1'b0;
        per_frame_clken = 1'b0;
        #2;
        n_cmp++;
        if ({post_frame_clken, post_img_Y, post_img_Cb, post_img_Cr} !== '0) begin
            n_bad++;
            $display("FAIL midreset outputs: got Y=%0d Cb=%0d Cr=%0d clken=%b want 0",
                     post_img_Y, post_img_Cb, post_img_Cr, post_frame_clken);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        model_order = 1'b1;
        repeat (4) drive(1'b0, 1'b0, 0, 0);
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL midreset stale: got %0d strobes want 0", obs_q.size()); end
        obs_q.delete();
        set_plan_line();
        model_line(4);
        drive_line(4, 0, s);
        n_cmp++;
        if (obs_q.size() != 4) begin n_bad++; $display("FAIL midreset count: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].y !== exp_q[i].y || obs_q[i].cb !== exp_q[i].cb || obs_q[i].cr !== exp_q[i].cr) begin
                n_bad++;
                $display("FAIL midreset px%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         obs_q[i].y, obs_q[i].cb, obs_q[i].cr, exp_q[i].y, exp_q[i].cb, exp_q[i].cr);
            end
        end
    endtask

    task automatic test_random();
        int s, n;
        bit err_exp;
        for (int f = 0; f < 6; f++) begin
            pulse_vsync(1'($urandom));
            err_exp = 1'b0;
            for (int l = 0; l < 3; l++) begin
                obs_q.delete(); exp_q.delete();
                n = int'($urandom_range(1, 8));
                for (int i = 0; i < n; i++) begin
                    line_c[i] = int'($urandom_range(0, (1 << DW) - 1));
                    line_y[i] = int'($urandom_range(0, (1 << DW) - 1));
                end
                model_line(n);
                err_exp |= (n % 2 == 1);
                drive_line(n, 2, s);
                n_cmp++;
                if (obs_q.size() != exp_q.size()) begin
                    n_bad++;
                    $display("FAIL rand f%0d l%0d count: got %0d want %0d", f, l, obs_q.size(), exp_q.size());
                end
                for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                    n_cmp++;
                    if (obs_q[i].y !== exp_q[i].y || obs_q[i].cb !== exp_q[i].cb || obs_q[i].cr !== exp_q[i].cr) begin
                        n_bad++;
                        $display("FAIL rand f%0d l%0d px%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", f, l, i,
                                 obs_q[i].y, obs_q[i].cb, obs_q[i].cr, exp_q[i].y, exp_q[i].cb, exp_q[i].cr);
                    end
                end
            end
            n_cmp++;
            if (odd_line_err !== err_exp) begin
                n_bad++;
                $display("FAIL rand f%0d err: got %b want %b", f, odd_line_err, err_exp);
            end
        end
    endtask

`ifdef YCBCR444_RANGE_CLAMP_EN
    task automatic test_clamp();
        int s;
        pulse_vsync(1'b1);
        obs_q.delete();
        line_c[0] = 1020; line_y[0] = 4;
        line_c[1] = 0;    line_y[1] = 1023;
        drive_line(2, 0, s);
        n_cmp++;
        if (obs_q.size() != 2 || obs_q[0].y !== 64 || obs_q[0].cb !== 960 || obs_q[0].cr !== 64
            || obs_q[1].y !== 940) begin
            n_bad++;
            $display("FAIL clamp: got %0d strobes px0=(%0d,%0d,%0d) want 2 strobes px0=(64,960,64) px1.Y=940",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0].y : -1,
                     obs_q.size() > 0 ? obs_q[0].cb : -1, obs_q.size() > 0 ? obs_q[0].cr : -1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_contiguous();
        test_order();
        test_sparse();
        test_odd_line();
        test_reset_midline();
        test_random();
`ifdef YCBCR444_RANGE_CLAMP_EN
        test_clamp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
